rat_seq_ctrl: RTL and testbench
===============================

Name: rat_seq_ctrl

Overview:
- Parametrised next-generation sequencer for the RAT MCU control path.
- Runs the INIT/FETCH/EXEC/INTERRUPT flow and adds:
  - NUM_IRQ prioritised, edge-captured interrupt sources with vectored entry;
  - configurable scratch-memory read wait states.
- Opcode decode lives in a separate combinational decoder. This block gates the decoded control bundle by phase, then drives the PC, SP, scratch RAM, register file and flags.

Parameters:
- NUM_IRQ, 4, number of interrupt sources (1..8); index 0 has highest priority.
- PC_W, 10, program counter width.
- VEC_BASE, 10'h3FF, vector address for IRQ 0; IRQ i vectors to VEC_BASE - i (mod 2^PC_W).
- MEM_WAIT, 0, extra EXEC cycles for instructions that read scratch RAM (0..7).

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- INTR  in  NUM_IRQ  interrupt request lines, synchronous to CLK.
- I_FLAG  in  1  current interrupt-enable register value.
- DEC_CTRL  in  ctrl_t  decoded control bundle for the current opcode.
- DEC_MEM_RD  in  1  current opcode reads scratch RAM (LD, POP, RET, RETIE, RETID).
- DEC_ILLEGAL  in  1  current opcode is undefined.
- CTRL  out  ctrl_t  gated control bundle to the datapath.
- IRQ_VEC  out  PC_W  vector address, valid while IRQ_ACK is non-zero (PC mux input 2).
- IRQ_ACK  out  NUM_IRQ  one-hot, one-cycle acknowledge of the serviced source.
- IRQ_PEND  out  NUM_IRQ  registered pending bits.

Behaviour:
- Reset and outputs:
  - RESET is sampled on the CLK edge and forces ST_INIT next cycle.
  - Reset clears pending bits, the wait counter and the INTR edge registers, regardless of the current state (including mid-EXEC and mid-INTERRUPT).
  - In ST_INIT, CTRL is all zero except RST=1; IRQ_ACK=0 and IRQ_VEC=0.
  - CTRL defaults to all zero in every state unless stated below.
- States (enum in package): ST_INIT, ST_FETCH, ST_EXEC, ST_WAIT, ST_INTERRUPT.
- ST_INIT -> ST_FETCH unconditionally.
- ST_FETCH: CTRL.PC_INC=1 -> ST_EXEC.
- ST_EXEC with DEC_MEM_RD=0 or MEM_WAIT=0:
  - CTRL = DEC_CTRL.
  - Exit check: if (|IRQ_PEND) && I_FLAG -> ST_INTERRUPT, else -> ST_FETCH.
- ST_EXEC with DEC_MEM_RD=1 and MEM_WAIT>0:
  - CTRL passes only the select fields (SCR_ADDR_SEL, RF_WR_SEL, PC_MUX_SEL, ALU_SEL, ALU_OPY_SEL). All write/load/strobe enables are forced 0.
  - Load wait counter with MEM_WAIT-1 -> ST_WAIT.
- ST_WAIT:
  - Same gating as above while counter != 0; decrement each cycle.
  - When counter == 0: CTRL = DEC_CTRL for exactly one cycle, then apply the ST_EXEC exit check.
  - Total EXEC span is 1+MEM_WAIT cycles.
- ST_INTERRUPT:
  - Asserts PC_LD, PC_MUX_SEL=2, SCR_DATA_SEL=1, SCR_WE, SCR_ADDR_SEL=3, SP_DECR, I_CLR, FLG_SHAD_LD.
  - Selects the lowest-index pending bit k: IRQ_ACK[k]=1, IRQ_VEC=VEC_BASE-k.
  - -> ST_FETCH.
- Pending logic:
  - Bit i sets on a rising edge of INTR[i] (edge register resets to 0).
  - Bit i clears on IRQ_ACK[i].
  - If set and clear occur in the same cycle, set wins.
  - Sources that are pending but not selected stay pending.
- The interrupt decision uses the I_FLAG value present in the final EXEC cycle. An SEI in that cycle takes effect only from the next instruction.
- DEC_ILLEGAL in ST_EXEC (feature off): CTRL is all zero except RST=1, then apply the normal exit check.
- The next state is always ST_INIT for any unencoded state value.

Optional Feature:
- Macro: RAT_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode does not assert RST. It enters ST_INTERRUPT with IRQ_VEC = VEC_BASE - NUM_IRQ, regardless of I_FLAG, and IRQ_ACK stays 0. Pending IRQs take over at the next instruction boundary.
- Undefined: RST pulse as described under Behaviour.

Decomposition:
- Package rat_ctrl_pkg holds:
  - ctrl_t packed struct (all 23 existing control signals);
  - state enum;
  - PC_MUX_SEL / SCR_ADDR_SEL / RF_WR_SEL encodings;
  - the CTRL_ZERO constant.
- Sub-module rat_irq_prio: edge capture, pending register, fixed-priority one-hot select and vector arithmetic.

Test Plan:
- Reset mid-ST_WAIT (MEM_WAIT=3, LD in progress): RESET high one cycle -> next cycle ST_INIT with RST=1, IRQ_PEND=0; no RF_WR pulse occurs.
- MEM_WAIT=2, POP decoded: RF_WR and SP_INCR each assert exactly once, on the 3rd EXEC cycle; SCR_ADDR_SEL=2 is held across all 3 cycles.
- INTR=4'b0110 edges during EXEC, I_FLAG=1 -> ST_INTERRUPT, IRQ_ACK=4'b0010, IRQ_VEC=10'h3FE. The next instruction boundary services IRQ 2 with IRQ_VEC=10'h3FD.
- INTR[0] rising edge with I_FLAG=0 -> no entry and IRQ_PEND[0] stays 1. After SEI, entry occurs at the end of the following instruction's EXEC.
- INTR[1] re-edges in the same cycle as IRQ_ACK[1] -> IRQ_PEND[1]=1 the cycle after.
- Illegal opcode: without the macro, RST=1 for one EXEC cycle. With RAT_ILLEGAL_TRAP_EN, ST_INTERRUPT with IRQ_VEC=10'h3FB (NUM_IRQ=4) and IRQ_ACK=0.

Source files
------------

// File: rtl/rat_ctrl_pkg.sv
// Shared types for the RAT MCU sequencer: control bundle, state encoding and mux selects.
package rat_ctrl_pkg;

    typedef struct packed {
        logic       PC_LD;
        logic       PC_INC;
        logic [1:0] PC_MUX_SEL;
        logic       ALU_OPY_SEL;
        logic [3:0] ALU_SEL;
        logic       RF_WR;
        logic [1:0] RF_WR_SEL;
        logic       SP_LD;
        logic       SP_INCR;
        logic       SP_DECR;
        logic       SCR_WE;
        logic [1:0] SCR_ADDR_SEL;
        logic       SCR_DATA_SEL;
        logic       FLG_C_SET;
        logic       FLG_C_CLR;
        logic       FLG_C_LD;
        logic       FLG_Z_LD;
        logic       FLG_LD_SEL;
        logic       FLG_SHAD_LD;
        logic       I_SET;
        logic       I_CLR;
        logic       IO_STRB;
        logic       RST;
    } ctrl_t;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_EXEC      = 3'd2,
        ST_WAIT      = 3'd3,
        ST_INTERRUPT = 3'd4
    } state_t;

    localparam logic [1:0] PC_MUX_IMM   = 2'd0;
    localparam logic [1:0] PC_MUX_STACK = 2'd1;
    localparam logic [1:0] PC_MUX_VEC   = 2'd2;

    localparam logic [1:0] SCR_ADDR_REG    = 2'd0;
    localparam logic [1:0] SCR_ADDR_IMM    = 2'd1;
    localparam logic [1:0] SCR_ADDR_SP     = 2'd2;
    localparam logic [1:0] SCR_ADDR_SP_DEC = 2'd3;

    localparam logic [1:0] RF_WR_ALU = 2'd0;
    localparam logic [1:0] RF_WR_SP  = 2'd1;
    localparam logic [1:0] RF_WR_SCR = 2'd2;
    localparam logic [1:0] RF_WR_IN  = 2'd3;

    localparam ctrl_t CTRL_ZERO = '0;

    // Keep mux selects stable while a scratch read settles; drop every enable.
    function automatic ctrl_t ctrl_sel_only(input ctrl_t c);
        ctrl_t r;
        r              = CTRL_ZERO;
        r.SCR_ADDR_SEL = c.SCR_ADDR_SEL;
        r.RF_WR_SEL    = c.RF_WR_SEL;
        r.PC_MUX_SEL   = c.PC_MUX_SEL;
        r.ALU_SEL      = c.ALU_SEL;
        r.ALU_OPY_SEL  = c.ALU_OPY_SEL;
        return r;
    endfunction

endpackage

// File: rtl/rat_seq_ctrl_irq_prio.sv
// Interrupt edge capture, pending register and fixed-priority vector select (index 0 wins).
module rat_irq_prio #(
    parameter int             NUM_IRQ  = 4,
    parameter int             PC_W     = 10,
    parameter logic [PC_W-1:0] VEC_BASE = 10'h3FF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_IRQ-1:0] INTR,
    input  logic [NUM_IRQ-1:0] ACK,
    output logic [NUM_IRQ-1:0] PEND,
    output logic [NUM_IRQ-1:0] SEL,
    output logic [PC_W-1:0]    VEC
);

    logic [NUM_IRQ-1:0] intr_q;

    // A fresh edge beats the acknowledge that clears the same bit.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            intr_q <= '0;
            PEND   <= '0;
        end else begin
            intr_q <= INTR;
            PEND   <= (PEND & ~ACK) | (INTR & ~intr_q);
        end
    end

    always_comb begin
        SEL = '0;
        VEC = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (PEND[i]) begin
                SEL    = '0;
                SEL[i] = 1'b1;
                VEC    = VEC_BASE - PC_W'(i);
            end
        end
    end

endmodule

// File: rtl/rat_seq_ctrl.sv
// RAT MCU sequencer: phase-gates the decoded control bundle, adds scratch-read wait states
// and vectored prioritised interrupts. RAT_ILLEGAL_TRAP_EN turns illegal opcodes into a trap.
module rat_seq_ctrl
    import rat_ctrl_pkg::*;
#(
    parameter int              NUM_IRQ  = 4,
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] VEC_BASE = 10'h3FF,
    parameter int              MEM_WAIT = 0
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_IRQ-1:0] INTR,
    input  logic               I_FLAG,
    input  ctrl_t              DEC_CTRL,
    input  logic               DEC_MEM_RD,
    input  logic               DEC_ILLEGAL,
    output ctrl_t              CTRL,
    output logic [PC_W-1:0]    IRQ_VEC,
    output logic [NUM_IRQ-1:0] IRQ_ACK,
    output logic [NUM_IRQ-1:0] IRQ_PEND
);

`ifdef RAT_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam bit              HAS_WAIT  = (MEM_WAIT > 0);
    localparam logic [2:0]      WAIT_LOAD = 3'(MEM_WAIT - 1);
    localparam logic [PC_W-1:0] TRAP_VEC  = VEC_BASE - PC_W'(NUM_IRQ);

    state_t             state;
    logic [2:0]         wait_cnt;
    logic               trap_q;
    logic [NUM_IRQ-1:0] irq_sel;
    logic [PC_W-1:0]    irq_vec;
    logic               take_irq;
    logic               exec_wait;
    logic               illegal_trap;

    assign take_irq     = (|IRQ_PEND) && I_FLAG;
    assign exec_wait    = DEC_MEM_RD && HAS_WAIT && !DEC_ILLEGAL;
    assign illegal_trap = DEC_ILLEGAL && TRAP_EN;

    rat_irq_prio #(
        .NUM_IRQ  (NUM_IRQ),
        .PC_W     (PC_W),
        .VEC_BASE (VEC_BASE)
    ) u_prio (
        .CLK   (CLK),
        .RESET (RESET),
        .INTR  (INTR),
        .ACK   (IRQ_ACK),
        .PEND  (IRQ_PEND),
        .SEL   (irq_sel),
        .VEC   (irq_vec)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= ST_INIT;
            wait_cnt <= '0;
            trap_q   <= 1'b0;
        end else begin
            case (state)
                ST_INIT:  state <= ST_FETCH;
                ST_FETCH: state <= ST_EXEC;
                ST_EXEC: begin
                    if (illegal_trap) begin
                        state  <= ST_INTERRUPT;
                        trap_q <= 1'b1;
                    end else if (exec_wait) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WAIT_LOAD;
                    end else begin
                        state <= take_irq ? ST_INTERRUPT : ST_FETCH;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt != 3'd0)
                        wait_cnt <= wait_cnt - 3'd1;
                    else
                        state <= take_irq ? ST_INTERRUPT : ST_FETCH;
                end
                ST_INTERRUPT: begin
                    state  <= ST_FETCH;
                    trap_q <= 1'b0;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    always_comb begin
        CTRL    = CTRL_ZERO;
        IRQ_ACK = '0;
        IRQ_VEC = '0;
        case (state)
            ST_INIT:  CTRL.RST    = 1'b1;
            ST_FETCH: CTRL.PC_INC = 1'b1;
            ST_EXEC: begin
                if (DEC_ILLEGAL)
                    CTRL.RST = !TRAP_EN;
                else if (exec_wait)
                    CTRL = ctrl_sel_only(DEC_CTRL);
                else
                    CTRL = DEC_CTRL;
            end
            ST_WAIT: CTRL = (wait_cnt != 3'd0) ? ctrl_sel_only(DEC_CTRL) : DEC_CTRL;
            ST_INTERRUPT: begin
                CTRL.PC_LD        = 1'b1;
                CTRL.PC_MUX_SEL   = PC_MUX_VEC;
                CTRL.SCR_DATA_SEL = 1'b1;
                CTRL.SCR_WE       = 1'b1;
                CTRL.SCR_ADDR_SEL = SCR_ADDR_SP_DEC;
                CTRL.SP_DECR      = 1'b1;
                CTRL.I_CLR        = 1'b1;
                CTRL.FLG_SHAD_LD  = 1'b1;
                if (trap_q) begin
                    IRQ_VEC = TRAP_VEC;
                end else begin
                    IRQ_ACK = irq_sel;
                    IRQ_VEC = irq_vec;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rat_seq_ctrl.sv
// Directed bench for rat_seq_ctrl: MEM_WAIT=2 instance for most checks, MEM_WAIT=3 for reset mid-wait.
module tb_rat_seq_ctrl;
    import rat_ctrl_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] INTR;
    logic       I_FLAG;
    ctrl_t      dec;
    logic       mem_rd;
    logic       illegal;

    ctrl_t      c2, c3;
    logic [9:0] v2, v3;
    logic [3:0] a2, a3, p2, p3;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    rat_seq_ctrl #(.NUM_IRQ(4), .PC_W(10), .VEC_BASE(10'h3FF), .MEM_WAIT(2)) dut (
        .CLK(CLK), .RESET(RESET), .INTR(INTR), .I_FLAG(I_FLAG), .DEC_CTRL(dec),
        .DEC_MEM_RD(mem_rd), .DEC_ILLEGAL(illegal), .CTRL(c2), .IRQ_VEC(v2),
        .IRQ_ACK(a2), .IRQ_PEND(p2)
    );

    rat_seq_ctrl #(.NUM_IRQ(4), .PC_W(10), .VEC_BASE(10'h3FF), .MEM_WAIT(3)) dut3 (
        .CLK(CLK), .RESET(RESET), .INTR(INTR), .I_FLAG(I_FLAG), .DEC_CTRL(dec),
        .DEC_MEM_RD(mem_rd), .DEC_ILLEGAL(illegal), .CTRL(c3), .IRQ_VEC(v3),
        .IRQ_ACK(a3), .IRQ_PEND(p3)
    );

    typedef struct {
        string name;
        ctrl_t dec;
        logic  mem_rd;
        ctrl_t exp;
        int    span;
    } vec_t;

    vec_t  tbl [6];
    ctrl_t RST_ONLY, FETCH_C, INT_C, ADD, LD, LD_G, POP, POP_G, SEI, ST, BRN, OUTP, CALL;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        RST_ONLY = '0; RST_ONLY.RST = 1'b1;
        FETCH_C  = '0; FETCH_C.PC_INC = 1'b1;
        INT_C    = '0;
        INT_C.PC_LD = 1'b1; INT_C.PC_MUX_SEL = 2'd2; INT_C.SCR_DATA_SEL = 1'b1; INT_C.SCR_WE = 1'b1;
        INT_C.SCR_ADDR_SEL = 2'd3; INT_C.SP_DECR = 1'b1; INT_C.I_CLR = 1'b1; INT_C.FLG_SHAD_LD = 1'b1;
        ADD  = '0; ADD.RF_WR = 1'b1; ADD.FLG_C_LD = 1'b1; ADD.FLG_Z_LD = 1'b1; ADD.ALU_SEL = 4'h0;
        ST   = '0; ST.SCR_WE = 1'b1; ST.SCR_ADDR_SEL = 2'd1;
        BRN  = '0; BRN.PC_LD = 1'b1; BRN.PC_MUX_SEL = 2'd0;
        OUTP = '0; OUTP.IO_STRB = 1'b1; OUTP.ALU_OPY_SEL = 1'b1;
        CALL = '0; CALL.PC_LD = 1'b1; CALL.SCR_WE = 1'b1; CALL.SCR_DATA_SEL = 1'b1;
        CALL.SCR_ADDR_SEL = 2'd3; CALL.SP_DECR = 1'b1;
        LD   = '0; LD.RF_WR = 1'b1; LD.RF_WR_SEL = 2'd2; LD.ALU_SEL = 4'hE; LD.SCR_ADDR_SEL = 2'd0;
        LD_G = '0; LD_G.RF_WR_SEL = 2'd2; LD_G.ALU_SEL = 4'hE;
        POP  = '0; POP.SP_INCR = 1'b1; POP.RF_WR = 1'b1; POP.RF_WR_SEL = 2'd2; POP.SCR_ADDR_SEL = 2'd2;
        POP_G = '0; POP_G.RF_WR_SEL = 2'd2; POP_G.SCR_ADDR_SEL = 2'd2;
        SEI  = '0; SEI.I_SET = 1'b1;

        tbl[0] = '{"add",  ADD,  1'b0, ADD,  1};
        tbl[1] = '{"st",   ST,   1'b0, ST,   1};
        tbl[2] = '{"brn",  BRN,  1'b0, BRN,  1};
        tbl[3] = '{"out",  OUTP, 1'b0, OUTP, 1};
        tbl[4] = '{"ld",   LD,   1'b1, LD_G, 3};
        tbl[5] = '{"call", CALL, 1'b0, CALL, 1};

        RESET = 1'b1; INTR = '0; I_FLAG = 1'b0; dec = '0; mem_rd = 1'b0; illegal = 1'b0;
        step(); step();
        chk("reset_ctrl", 64'(c2), 64'(RST_ONLY));
        chk("reset_ack",  64'(a2), 64'd0);
        chk("reset_vec",  64'(v2), 64'd0);
        chk("reset_pend", 64'(p2), 64'd0);
        RESET = 1'b0;
        step();
        chk("first_fetch", 64'(c2), 64'(FETCH_C));

        // LD on the 3-wait instance, reset while it is still waiting
        dec = LD; mem_rd = 1'b1; INTR = 4'b0001;
        step();
        chk("w3_exec_gated", 64'(c3), 64'(LD_G));
        chk("w3_pend_set",   64'(p3), 64'd1);
        step();
        chk("w3_wait_gated", 64'(c3), 64'(LD_G));
        RESET = 1'b1;
        step();
        chk("w3_reset_ctrl", 64'(c3), 64'(RST_ONLY));
        chk("w3_reset_pend", 64'(p3), 64'd0);
        chk("w3_no_rf_wr",   64'(c3.RF_WR), 64'd0);
        RESET = 1'b0; INTR = '0; mem_rd = 1'b0; dec = '0;
        step();
        chk("w3_refetch", 64'(c3), 64'(FETCH_C));

        for (int i = 0; i < 6; i++) begin
            int n;
            chk({tbl[i].name, "_fetch"}, 64'(c2), 64'(FETCH_C));
            dec = tbl[i].dec; mem_rd = tbl[i].mem_rd;
            step();
            chk({tbl[i].name, "_exec"}, 64'(c2), 64'(tbl[i].exp));
            n = 0;
            do begin
                step();
                n++;
            end while (!c2.PC_INC && n < 10);
            chk({tbl[i].name, "_span"}, 64'(n), 64'(tbl[i].span));
        end
        mem_rd = 1'b0;

        // POP with two wait states
        dec = POP; mem_rd = 1'b1;
        step(); chk("pop_c1", 64'(c2), 64'(POP_G));
        step(); chk("pop_c2", 64'(c2), 64'(POP_G));
        step(); chk("pop_c3", 64'(c2), 64'(POP));
        step(); chk("pop_end", 64'(c2), 64'(FETCH_C));
        mem_rd = 1'b0;

        // two simultaneous edges, serviced in priority order
        dec = ADD; I_FLAG = 1'b1; INTR = 4'b0110;
        step(); chk("irq_pend2", 64'(p2), 64'h6); chk("irq_exec", 64'(c2), 64'(ADD));
        step(); chk("irq1_ack", 64'(a2), 64'h2); chk("irq1_vec", 64'(v2), 64'h3FE);
        chk("irq1_ctrl", 64'(c2), 64'(INT_C));
        step(); chk("irq1_left", 64'(p2), 64'h4); chk("irq1_fetch", 64'(c2), 64'(FETCH_C));
        step();
        step(); chk("irq2_ack", 64'(a2), 64'h4); chk("irq2_vec", 64'(v2), 64'h3FD);
        step(); chk("irq2_clear", 64'(p2), 64'h0); chk("irq2_ack_off", 64'(a2), 64'h0);

        // masked source waits for SEI plus one instruction
        I_FLAG = 1'b0; INTR = 4'b0111;
        step(); chk("mask_pend", 64'(p2), 64'h1);
        step(); chk("mask_noentry", 64'(c2), 64'(FETCH_C)); chk("mask_hold", 64'(p2), 64'h1);
        dec = SEI;
        step(); chk("sei_exec", 64'(c2), 64'(SEI));
        step(); chk("sei_noentry", 64'(c2), 64'(FETCH_C));
        I_FLAG = 1'b1; dec = ADD;
        step();
        step(); chk("irq0_ack", 64'(a2), 64'h1); chk("irq0_vec", 64'(v2), 64'h3FF);
        step(); chk("irq0_clear", 64'(p2), 64'h0);

        // re-edge on IRQ 1 in the same cycle as its acknowledge
        INTR = 4'b0000;
        step(); step();
        INTR = 4'b0010;
        step(); chk("re_pend", 64'(p2), 64'h2);
        INTR = 4'b0000;
        step(); chk("re_ack", 64'(a2), 64'h2);
        INTR = 4'b0010;
        step(); chk("re_setwins", 64'(p2), 64'h2);
        step();
        step(); chk("re_ack2", 64'(a2), 64'h2);
        step(); chk("re_clear", 64'(p2), 64'h0);
        INTR = 4'b0000;

        // illegal opcode
        I_FLAG = 1'b0; dec = ADD; illegal = 1'b1;
        step();
`ifdef RAT_ILLEGAL_TRAP_EN
        chk("ill_exec", 64'(c2), 64'd0);
        step();
        chk("trap_ctrl", 64'(c2), 64'(INT_C));
        chk("trap_vec",  64'(v2), 64'h3FB);
        chk("trap_ack",  64'(a2), 64'h0);
        step();
        chk("trap_fetch", 64'(c2), 64'(FETCH_C));
`else
        chk("ill_exec", 64'(c2), 64'(RST_ONLY));
        step();
        chk("ill_fetch", 64'(c2), 64'(FETCH_C));
`endif
        illegal = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
